// File: rtl/divider_32_seq.sv
// Multi-cycle signed divider: radix-2 restoring, one quotient bit per clock.
// Z packs {remainder, quotient} to match the HI/LO mult/div convention.
module divider_32_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic                 done,
  output logic                 div_by_zero,
  output logic [WIDTH-1:0]     Q,
  output logic [WIDTH-1:0]     R,
  output logic [2*WIDTH-1:0]   Z
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIVIDE,
    S_FIX,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic             r_sign_a;
  logic             r_sign_q;
  logic             r_dz;
  logic [WIDTH:0]   r_mag_b;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH:0]   w_mag_b;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH+1:0] w_trial;
  logic             w_b_zero;

  // |A| fits WIDTH unsigned bits even for the most negative value
  assign w_mag_a  = A[WIDTH-1] ? (~A + 1'b1) : A;
  assign w_mag_b  = B[WIDTH-1] ? {1'b0, ~B + 1'b1} : {1'b0, B};
  assign w_b_zero = (B == '0);

  assign w_rem_sh = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
  assign w_trial  = {1'b0, w_rem_sh} - {1'b0, r_mag_b};

  assign Z = {R, Q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = w_b_zero ? S_DONE : S_DIVIDE;
      S_DIVIDE: if (r_cnt == CW'(1)) w_next = S_FIX;
      S_FIX:    w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign_a    <= 1'b0;
      r_sign_q    <= 1'b0;
      r_dz        <= 1'b0;
      r_mag_b     <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_cnt       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      Q           <= '0;
      R           <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sign_a    <= A[WIDTH-1];
            r_sign_q    <= A[WIDTH-1] ^ B[WIDTH-1];
            r_dz        <= w_b_zero;
            r_mag_b     <= w_mag_b;
            r_quo       <= w_mag_a;
            r_rem       <= '0;
            r_cnt       <= CW'(WIDTH);
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
          end
        end
        S_DIVIDE: begin
          // trial result negative -> restore the shifted remainder
          if (w_trial[WIDTH+1]) begin
            r_rem <= w_rem_sh;
            r_quo <= {r_quo[WIDTH-2:0], 1'b0};
          end else begin
            r_rem <= w_trial[WIDTH:0];
            r_quo <= {r_quo[WIDTH-2:0], 1'b1};
          end
          r_cnt <= r_cnt - 1'b1;
        end
        S_FIX: begin
          Q <= r_sign_q ? (~r_quo + 1'b1) : r_quo;
          R <= r_sign_a ? WIDTH'(~r_rem + 1'b1) : WIDTH'(r_rem);
        end
        S_DONE: begin
          busy <= 1'b0;
          done <= 1'b1;
          // divide by zero skips the datapath; r_quo still holds |A|
          if (r_dz) begin
            Q           <= '1;
            R           <= r_sign_a ? (~r_quo + 1'b1) : r_quo;
            div_by_zero <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
